// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the eight-digit seven-segment scan driver:
//   NUM_DIGITS   number of multiplexed digits
//   SEG_OFF      all segments / all anodes off (active-low)
//   HEX_FONT     0-F glyphs, {dp,g,f,e,d,c,b,a}, active-low, dp off
//   disp_mode_e  MODE_HEX (0) renders nibbles, MODE_GFX (1) passes raw bytes
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

  localparam logic [7:0] HEX_FONT [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_GFX = 1'b1
  } disp_mode_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex-digit to seven-segment glyph lookup.
// Ports:
//   i_nib  [3:0]  hex digit value
//   o_seg  [7:0]  glyph {dp,g,f,e,d,c,b,a}, active-low, dp always off
// -----------------------------------------------------------------------------
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);

  assign o_seg = HEX_FONT[i_nib];

endmodule

// File: rtl/seg7_scan64.sv
// -----------------------------------------------------------------------------
// seg7_scan64
// Time-multiplexed driver for an eight-digit common-anode seven-segment
// display. The 64-bit display word and mode bit are captured once per frame
// (at the end of digit 7's slot) so a frame never mixes old and new data.
//   Hex mode     : digit k shows nibble k of the low 32 bits.
//   Graphic mode : digit k shows raw segment byte k.
// Each slot starts with BLANK_CYC cycles of all anodes off to avoid ghosting.
//
// Parameters:
//   SCAN_DIV_W  slot length is 2^SCAN_DIV_W clk cycles
//   BLANK_CYC   anode-off cycles at the start of each slot (< 2^SCAN_DIV_W)
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   i_data     [63:0] display word
//   disp_mode  0 = hex, 1 = graphic
//   o_seg      [7:0] segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   o_sel      [7:0] anodes, active-low, bit k = digit k (0 = rightmost)
// Build option:
//   SEG7_LZ_BLANK_EN  leading-zero blanking in hex mode (digit 0 always lit)
// -----------------------------------------------------------------------------
module seg7_scan64
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV_W = 15,
  parameter int BLANK_CYC  = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] i_data,
  input  logic        disp_mode,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel
);

  localparam logic [SCAN_DIV_W-1:0] BLANK_LIM = SCAN_DIV_W'(BLANK_CYC);

  logic [SCAN_DIV_W-1:0] r_pre;
  logic [2:0]            r_dig;
  logic [63:0]           r_shadow;
  disp_mode_e            r_mode_q;

  logic       w_slot_end;
  logic       w_latch;
  logic [3:0] w_nib;
  logic [7:0] w_font;
  logic [7:0] w_byte;
  logic [7:0] w_seg_next;
  logic [7:0] w_sel_next;
  logic       w_digit_blank;

  assign w_slot_end = &r_pre;
  assign w_latch    = w_slot_end && (r_dig == 3'd7);

  // Prescaler, digit counter and frame latch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre    <= '0;
      r_dig    <= '0;
      r_shadow <= '0;
      r_mode_q <= MODE_HEX;
    end else begin
      r_pre <= r_pre + SCAN_DIV_W'(1);
      if (w_slot_end) begin
        r_dig <= r_dig + 3'd1;
      end
      if (w_latch) begin
        r_shadow <= i_data;
        r_mode_q <= disp_mode_e'(disp_mode);
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  // Blank mask for leading zeros: bit k set when nibbles k..7 are all zero.
  // Built from i_data at the latch edge so it always matches r_shadow.
  // Digit 0 is never blanked so a zero word still shows "0".
  logic [NUM_DIGITS-1:0] r_lz_mask;
  logic [NUM_DIGITS-1:0] w_lz_next;

  assign w_lz_next[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign w_lz_next[gi] = ~|i_data[31:4*gi];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lz_mask <= 8'hFE;  // shadow clears to zero: only digit 0 lit
    end else if (w_latch) begin
      r_lz_mask <= w_lz_next;
    end
  end

  assign w_digit_blank = (r_mode_q == MODE_HEX) && r_lz_mask[r_dig];
`else
  assign w_digit_blank = 1'b0;
`endif

  assign w_nib  = r_shadow[{r_dig, 2'b00} +: 4];
  assign w_byte = r_shadow[{r_dig, 3'b000} +: 8];

  seg7_hex_decode u_hex_decode (
    .i_nib (w_nib),
    .o_seg (w_font)
  );

  always_comb begin
    w_seg_next = w_font;
    w_sel_next = ~(8'h01 << r_dig);
    if (r_mode_q == MODE_GFX) begin
      w_seg_next = w_byte;
    end
    if ((r_pre < BLANK_LIM) || w_digit_blank) begin
      w_sel_next = SEG_OFF;
    end
  end

  // Registered outputs: one cycle behind the pre/dig state they decode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_seg <= SEG_OFF;
      o_sel <= SEG_OFF;
    end else begin
      o_seg <= w_seg_next;
      o_sel <= w_sel_next;
    end
  end

endmodule
